cache_mem_resp: RTL and testbench
=================================

Name: cache_mem_resp

Overview:
Main-memory responder for the cache line-fill interface; it is the memory-side end of the protocol the caches drive through mem_req/mem_data. It accepts one cache-line read or write request at a time. After a programmable latency it returns a full line with a one-cycle ready pulse. It sits between the i_cache/d_cache request ports and a line-organised backing store held in this block.

Parameters:
LINE_W, 128, cache line width in bits (16-byte line, address bits [3:0] are byte offset)
DEPTH, 1024, number of lines in backing store; power of two
LATENCY, 4, clock edges from request capture to ready pulse; legal range 1..255

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mem_req_valid_i  in  1  request valid; held high by requester until ready seen
mem_req_rw_i  in  1  1 = write line, 0 = read line
mem_req_addr_i  in  32  byte address; bits [3:0] ignored
mem_req_data_i  in  LINE_W  write line data
mem_data_ready_o  out  1  one-cycle response pulse
mem_data_data_o  out  LINE_W  read line data, valid while ready high
mem_err_o  out  1  pulses with ready when address out of range
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_ni low): state IDLE, ready 0, data_o 0, err 0, busy 0, latency counter 0. Backing store contents are not cleared. Reset asserted mid-request aborts the request: no ready, and a pending write is not committed.
- States: IDLE, BUSY, RESP, TURN.
- IDLE: on an edge with valid_i = 1, capture rw, addr, and data into registers; load counter with LATENCY-1; go to BUSY. Inputs are ignored in all other states.
- BUSY: counter decrements each edge. When counter = 0, go to RESP at the next edge. This gives exactly LATENCY edges in BUSY.
- Ready timing: ready rises exactly LATENCY edges after the capturing edge.
- Entering RESP:
  - Read: data_o = store[line_idx].
  - Write: store[line_idx] written on the same edge; data_o = written data (echo).
  - ready = 1 for exactly one cycle.
- RESP: always goes to TURN next edge. ready returns to 0; data_o holds its value until the next response.
- TURN: one dead cycle. valid_i is ignored, so a requester that drops valid the cycle after ready is never double-served. Go to IDLE next edge.
- Back-to-back throughput: one request per LATENCY+3 cycles.
- line_idx = addr[log2(DEPTH)+3:4].
- Out of range: address with any bit above log2(DEPTH)+3 set.
  - Read returns all zeros; write is dropped.
  - err = 1 for the same cycle as ready.
  - The same state timing applies as for an in-range access.
- Captured request registers are used for the whole transaction. Input changes after capture have no effect.
- Simultaneous valid_i and ready cannot re-trigger: capture occurs only in IDLE.

Optional Feature:
Macro MEM_RESP_STATS_EN.
- Defined: adds outputs no_rd_o[31:0], no_wr_o[31:0], and no_err_o[31:0].
  - Each counter increments on the RESP-entry edge for reads, writes, and errors respectively. Reads and writes are counted even when err is set.
  - Counters saturate at 0xFFFFFFFF and reset to 0 asynchronously.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Reset then idle: hold rst_ni low 3 cycles, release -> ready, err, busy, and data_o all 0; no ready for 20 cycles with valid low.
2. Write then read: write addr 0x0000_0040 data 0x0123..CDEF (128-bit), LATENCY=4 -> ready exactly 4 edges after capture. Read same address -> data_o = same 128-bit value, err 0.
3. Latency sweep: LATENCY = 1, 4, 255 -> ready rises 1 / 4 / 255 edges after capture; ready width is always 1 cycle.
4. Held valid: keep valid high 3 cycles past ready -> only one response; next capture happens only after TURN, once valid is re-sampled in IDLE.
5. Out of range, DEPTH=1024: read addr 0x0001_0000 -> data_o 0, err pulses with ready. Write to the same address -> later in-range reads are unaffected.
6. Reset mid-BUSY: issue write to 0x80, assert rst_ni 2 cycles after capture -> no ready pulse; subsequent read of 0x80 returns the old contents. With MEM_RESP_STATS_EN, no_wr_o = 0.

Source files
------------

// File: rtl/cache_mem_resp.sv
// cache_mem_resp: main-memory responder for the cache line-fill interface.
// Accepts one line read/write at a time. It returns a one-cycle ready pulse
// LATENCY edges after the request is captured. The backing store is line
// organised and is not cleared by reset.
// Optional statistics counters are built when MEM_RESP_STATS_EN is defined.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   mem_req_valid_i         request valid, held by requester until ready
//   mem_req_rw_i            1 = write line, 0 = read line
//   mem_req_addr_i          byte address, bits [3:0] ignored
//   mem_req_data_i          write line data
//   mem_data_ready_o        one-cycle response pulse
//   mem_data_data_o         read data or write echo, held until next response
//   mem_err_o               pulses with ready for an out-of-range address
//   busy_o                  high whenever a transaction is in progress
//   no_rd_o/no_wr_o/no_err_o  saturating counters (MEM_RESP_STATS_EN only)
module cache_mem_resp #(
   parameter int LINE_W  = 128,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              mem_req_valid_i,
   input  logic              mem_req_rw_i,
   input  logic [31:0]       mem_req_addr_i,
   input  logic [LINE_W-1:0] mem_req_data_i,
   output logic              mem_data_ready_o,
   output logic [LINE_W-1:0] mem_data_data_o,
   output logic              mem_err_o,
   output logic              busy_o
`ifdef MEM_RESP_STATS_EN
   ,
   output logic [31:0]       no_rd_o,
   output logic [31:0]       no_wr_o,
   output logic [31:0]       no_err_o
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP, TURN} state_t;

   state_t            r_state;
   logic [7:0]        r_cnt;
   logic              r_rw;
   logic [31:4]       r_addr;
   logic [LINE_W-1:0] r_wdata;
   logic [LINE_W-1:0] r_data;
   logic              r_ready;
   logic              r_err;
   logic              r_busy;
   logic [LINE_W-1:0] r_store [DEPTH];

   logic [AW-1:0]     w_idx;
   logic              w_oor;
   logic              w_fire;
   logic              w_unused;

   assign w_idx    = r_addr[AW+3:4];
   assign w_oor    = |r_addr[31:AW+4];
   // the edge that leaves BUSY is the response edge: store write and output load
   assign w_fire   = (r_state == BUSY) && (r_cnt == 8'd0);
   assign w_unused = ^mem_req_addr_i[3:0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_rw    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_data  <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (mem_req_valid_i) begin
               r_state <= BUSY;
               r_cnt   <= LAT_M1;
               r_rw    <= mem_req_rw_i;
               r_addr  <= mem_req_addr_i[31:4];
               r_wdata <= mem_req_data_i;
               r_busy  <= 1'b1;
            end
            BUSY: if (r_cnt == 8'd0) begin
               r_state <= RESP;
               r_ready <= 1'b1;
               r_err   <= w_oor;
               r_data  <= r_rw ? r_wdata : (w_oor ? '0 : r_store[w_idx]);
            end else begin
               r_cnt <= r_cnt - 8'd1;
            end
            RESP: begin
               r_state <= TURN;
               r_ready <= 1'b0;
               r_err   <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // no reset on the store: contents survive reset, and an aborted write
   // never reaches w_fire because reset forces the FSM back to IDLE
   always_ff @(posedge clk_i) begin
      if (w_fire && r_rw && !w_oor) r_store[w_idx] <= r_wdata;
   end

   assign mem_data_ready_o = r_ready;
   assign mem_data_data_o  = r_data;
   assign mem_err_o        = r_err;
   assign busy_o           = r_busy;

`ifdef MEM_RESP_STATS_EN
   logic [31:0] r_no_rd;
   logic [31:0] r_no_wr;
   logic [31:0] r_no_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_no_rd  <= '0;
         r_no_wr  <= '0;
         r_no_err <= '0;
      end else if (w_fire) begin
         if (!r_rw && !(&r_no_rd)) r_no_rd <= r_no_rd + 32'd1;
         if (r_rw && !(&r_no_wr)) r_no_wr <= r_no_wr + 32'd1;
         if (w_oor && !(&r_no_err)) r_no_err <= r_no_err + 32'd1;
      end
   end

   assign no_rd_o  = r_no_rd;
   assign no_wr_o  = r_no_wr;
   assign no_err_o = r_no_err;
`else
   // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_cache_mem_resp.sv
// tb_cache_mem_resp: self-checking bench for cache_mem_resp (latencies 1, 4, 255).
module tb_cache_mem_resp;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid = 1'b0;
   logic          rw = 1'b0;
   logic [31:0]   addr = '0;
   logic [LW-1:0] wdata = '0;

   logic          rdy4, rdy1, rdy255, err4, err1, err255, busy4, busy1, busy255;
   logic [LW-1:0] dat4, dat1, dat255;
`ifdef MEM_RESP_STATS_EN
   logic [31:0]   rd4, wr4, er4, rd1, wr1, er1, rd255, wr255, er255;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cache_mem_resp #(.LATENCY(4)) u_lat4 (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_valid_i(valid), .mem_req_rw_i(rw),
      .mem_req_addr_i(addr), .mem_req_data_i(wdata), .mem_data_ready_o(rdy4),
      .mem_data_data_o(dat4), .mem_err_o(err4), .busy_o(busy4)
`ifdef MEM_RESP_STATS_EN
      , .no_rd_o(rd4), .no_wr_o(wr4), .no_err_o(er4)
`endif
   );

   cache_mem_resp #(.LATENCY(1)) u_lat1 (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_valid_i(valid), .mem_req_rw_i(rw),
      .mem_req_addr_i(addr), .mem_req_data_i(wdata), .mem_data_ready_o(rdy1),
      .mem_data_data_o(dat1), .mem_err_o(err1), .busy_o(busy1)
`ifdef MEM_RESP_STATS_EN
      , .no_rd_o(rd1), .no_wr_o(wr1), .no_err_o(er1)
`endif
   );

   cache_mem_resp #(.LATENCY(255)) u_lat255 (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_valid_i(valid), .mem_req_rw_i(rw),
      .mem_req_addr_i(addr), .mem_req_data_i(wdata), .mem_data_ready_o(rdy255),
      .mem_data_data_o(dat255), .mem_err_o(err255), .busy_o(busy255)
`ifdef MEM_RESP_STATS_EN
      , .no_rd_o(rd255), .no_wr_o(wr255), .no_err_o(er255)
`endif
   );

   function automatic void chk_b(string name, logic act, logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endfunction

   function automatic void chk_i(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void chk_d(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   typedef struct {
      logic [LW-1:0] d;
      logic          e;
      logic          c;
   } exp_t;

   exp_t sb[$];
   logic prev4 = 1'b0;

   // scoreboard: every ready pulse of the LATENCY=4 instance pops one expectation
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         prev4 = 1'b0;
      end else begin
         if (rdy4) begin
            chk_b("ready_width", prev4, 1'b0);
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_unexpected_response: got data %h, no response expected", dat4);
            end else begin
               e = sb.pop_front();
               if (e.c) chk_d("rsp_data", dat4, e.d);
               chk_b("rsp_err", err4, e.e);
            end
         end else if (err4) begin
            tests++;
            fails++;
            $display("FAIL err_without_ready: got err 1 expected 0");
         end
         prev4 = rdy4;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy4 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk_b("idle_before_req", busy4, 1'b0);
   endtask

   task automatic do_req(input logic r, input logic [31:0] a, input logic [LW-1:0] d,
                         input logic [LW-1:0] ed, input logic ee, input logic cd);
      int n;
      wait_idle();
      valid = 1'b1;
      rw    = r;
      addr  = a;
      wdata = d;
      sb.push_back('{ed, ee, cd});
      @(posedge clk);
      #1 chk_b("busy_after_capture", busy4, 1'b1);
      n = 0;
      while (n < 300) begin
         @(posedge clk);
         n++;
         #1;
         if (rdy4) break;
      end
      chk_i("latency4", n, 4);
      @(posedge clk);
      #1 chk_b("ready_drops", rdy4, 1'b0);
      if (cd) chk_d("data_hold", dat4, ed);
      valid = 1'b0;
   endtask

   typedef struct {
      logic          rw;
      logic [31:0]   a;
      logic [LW-1:0] d;
      logic [LW-1:0] ed;
      logic          ee;
      logic          cd;
   } vec_t;

   localparam logic [LW-1:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [LW-1:0] D1 = 128'hDEADBEEF00000000FFFFFFFF12345678;
   localparam logic [LW-1:0] D2 = {4{32'hA5A55A5A}};
   localparam logic [LW-1:0] D3 = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
   localparam logic [LW-1:0] D4 = 128'h1;
   localparam logic [LW-1:0] D5 = {4{32'hCAFEF00D}};
   localparam logic [LW-1:0] D6 = {4{32'h0BADC0DE}};
   localparam logic [LW-1:0] Z  = '0;

   vec_t tbl[15];

   initial begin
      int t1, t4, t255, x1, x4, x255, cnt;
      logic e1, e255;

      tbl[0]  = '{1'b1, 32'h0000_0040, D0, D0, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 32'h0000_0040, Z,  D0, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 32'h0000_0050, D1, D1, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 32'h0000_0050, Z,  D1, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 32'h0000_0000, D4, D4, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 32'h0001_0000, D5, Z,  1'b1, 1'b1};
      tbl[6]  = '{1'b1, 32'h0001_0000, D2, Z,  1'b1, 1'b0};
      tbl[7]  = '{1'b0, 32'h0000_0000, Z,  D4, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 32'h0000_0040, Z,  D0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 32'h0000_004F, Z,  D0, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 32'h0000_3FF0, D3, D3, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 32'h0000_3FF0, Z,  D3, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 32'h0000_4000, Z,  Z,  1'b1, 1'b1};
      tbl[13] = '{1'b0, 32'h8000_0000, Z,  Z,  1'b1, 1'b1};
      tbl[14] = '{1'b0, 32'h0000_0000, Z,  D4, 1'b0, 1'b1};

      // reset then idle
      repeat (3) @(posedge clk);
      #1;
      chk_b("rst_ready", rdy4, 1'b0);
      chk_b("rst_err", err4, 1'b0);
      chk_b("rst_busy", busy4, 1'b0);
      chk_d("rst_data", dat4, Z);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (rdy4 || rdy1 || rdy255) cnt++;
      end
      chk_i("idle_no_ready", cnt, 0);

      // latency sweep: one-cycle valid pulse captured by all three instances
      @(negedge clk);
      valid = 1'b1;
      rw    = 1'b0;
      addr  = 32'h0001_0000;
      sb.push_back('{Z, 1'b1, 1'b1});
      @(negedge clk);
      valid = 1'b0;
      t1 = -1; t4 = -1; t255 = -1; x1 = 0; x4 = 0; x255 = 0; e1 = 1'b0; e255 = 1'b0;
      for (int n = 1; n <= 262; n++) begin
         @(posedge clk);
         #1;
         if (rdy1) begin
            if (t1 < 0) begin t1 = n; e1 = err1; end else x1++;
         end
         if (rdy4) begin
            if (t4 < 0) t4 = n; else x4++;
         end
         if (rdy255) begin
            if (t255 < 0) begin t255 = n; e255 = err255; end else x255++;
         end
      end
      chk_i("sweep_lat1", t1, 1);
      chk_i("sweep_lat4", t4, 4);
      chk_i("sweep_lat255", t255, 255);
      chk_i("sweep_extra1", x1, 0);
      chk_i("sweep_extra4", x4, 0);
      chk_i("sweep_extra255", x255, 0);
      chk_b("sweep_err1", e1, 1'b1);
      chk_b("sweep_err255", e255, 1'b1);

      // table-driven transactions on the LATENCY=4 instance
      for (int i = 0; i < 15; i++)
         do_req(tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].ed, tbl[i].ee, tbl[i].cd);

      // held valid: one response, recapture only after TURN
      wait_idle();
      valid = 1'b1;
      rw    = 1'b0;
      addr  = 32'h0000_0040;
      sb.push_back('{D0, 1'b0, 1'b1});
      sb.push_back('{D0, 1'b0, 1'b1});
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1 chk_b("hold_first_ready", rdy4, 1'b1);
      @(posedge clk);
      #1 chk_b("hold_turn_ready", rdy4, 1'b0);
      chk_b("hold_turn_busy", busy4, 1'b1);
      @(posedge clk);
      #1 chk_b("hold_idle_busy", busy4, 1'b0);
      @(posedge clk);
      #1 chk_b("hold_recapture", busy4, 1'b1);
      @(negedge clk);
      valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_b("hold_no_early_ready", rdy4, 1'b0);
      @(posedge clk);
      #1 chk_b("hold_second_ready", rdy4, 1'b1);

      // reset in the middle of a write aborts it
      do_req(1'b1, 32'h0000_0080, D5, D5, 1'b0, 1'b1);
      wait_idle();
      valid = 1'b1;
      rw    = 1'b1;
      addr  = 32'h0000_0080;
      wdata = D6;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_b("abort_busy", busy4, 1'b0);
      chk_b("abort_ready", rdy4, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (rdy4) cnt++;
      end
      chk_i("abort_no_ready", cnt, 0);
`ifdef MEM_RESP_STATS_EN
      chk_i("stats_wr_after_abort", int'(wr4), 0);
      chk_i("stats_rd_after_abort", int'(rd4), 0);
      chk_i("stats_err_after_abort", int'(er4), 0);
`endif
      do_req(1'b0, 32'h0000_0080, Z, D5, 1'b0, 1'b1);
`ifdef MEM_RESP_STATS_EN
      chk_i("stats_rd_after_read", int'(rd4), 1);
      chk_i("stats_wr_after_read", int'(wr4), 0);
`endif

      repeat (10) @(posedge clk);
      chk_i("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
